// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic array result drain.
package systolic_pkg;

   localparam int unsigned N_RES = 16;
   localparam int unsigned RES_W = 8;
   localparam logic [RES_W-1:0] HEADER_DEF = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_CSUM = 2'd3
   } state_e;

endpackage

// File: rtl/systolic_result_drain.sv
// Captures the 4x4 array results and drains them to a UART as a framed byte
// stream: header, N_RES result bytes, then the XOR checksum of the results.
module systolic_result_drain
   import systolic_pkg::state_e;
   import systolic_pkg::ST_IDLE;
   import systolic_pkg::ST_HDR;
   import systolic_pkg::ST_DATA;
   import systolic_pkg::ST_CSUM;
   import systolic_pkg::RES_W;
   import systolic_pkg::HEADER_DEF;
#(
   parameter logic [RES_W-1:0] HEADER = HEADER_DEF,
   parameter int unsigned      N_RES  = systolic_pkg::N_RES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cap,
   input  logic [RES_W*N_RES-1:0] c_in,
   output logic [RES_W-1:0]       tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overrun
);

   localparam int unsigned IDX_W = (N_RES > 1) ? $clog2(N_RES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_RES - 1);

   state_e                        state_q, state_d;
   logic [N_RES-1:0][RES_W-1:0]   buf_q, buf_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [RES_W-1:0]              csum_q, csum_d;
   logic [RES_W-1:0]              tx_data_q, tx_data_d;
   logic                          tx_valid_q, tx_valid_d;
   logic                          busy_q, busy_d;
   logic                          frame_done_q, frame_done_d;
   logic                          overrun_q, overrun_d;

   logic                          xfer;
   logic                          accept;
   logic [RES_W-1:0]              cap_xor;
   logic [IDX_W-1:0]              rd_idx;
   logic [RES_W-1:0]              rd_byte;

   assign xfer   = tx_valid_q & tx_ready;
   // A capture is taken in IDLE, or back-to-back on the checksum transfer edge.
   assign accept = cap & ((state_q == ST_IDLE) | ((state_q == ST_CSUM) & xfer));

   always_comb begin
      cap_xor = '0;
      for (int i = 0; i < int'(N_RES); i++) begin
         cap_xor = cap_xor ^ c_in[i*RES_W +: RES_W];
      end
   end

   // Byte offered after the current transfer: C0 after the header, else the next index.
   assign rd_idx  = (state_q == ST_HDR) ? '0 : IDX_W'(idx_q + IDX_W'(1));
   assign rd_byte = buf_q[rd_idx];

   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      idx_d        = idx_q;
      csum_d       = csum_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q;

      case (state_q)
         ST_HDR: begin
            if (xfer) begin
               state_d   = ST_DATA;
               idx_d     = '0;
               tx_data_d = rd_byte;
            end
         end
         ST_DATA: begin
            if (xfer) begin
               if (idx_q == IDX_LAST) begin
                  state_d   = ST_CSUM;
                  idx_d     = '0;
                  tx_data_d = csum_q;
               end else begin
                  idx_d     = IDX_W'(idx_q + IDX_W'(1));
                  tx_data_d = rd_byte;
               end
            end
         end
         ST_CSUM: begin
            if (xfer) begin
               state_d      = ST_IDLE;
               tx_valid_d   = 1'b0;
               frame_done_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (accept) begin
         state_d    = ST_HDR;
         buf_d      = c_in;
         csum_d     = cap_xor;
         idx_d      = '0;
         tx_data_d  = HEADER;
         tx_valid_d = 1'b1;
         overrun_d  = 1'b0;
      end else if (cap) begin
         overrun_d  = 1'b1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         buf_q        <= '0;
         idx_q        <= '0;
         csum_q       <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         idx_q        <= idx_d;
         csum_q       <= csum_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed and randomized checks of the result drain against a frame-level
// model: header, captured bytes in order, XOR checksum.
module tb_systolic_result_drain;

   logic         clk = 1'b0;
   logic         reset;
   logic         cap;
   logic [127:0] c_in;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         busy;
   logic         frame_done;
   logic         overrun;

   int checks   = 0;
   int failures = 0;

   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         xfer_edges[$];
   int         edge_n;
   int         fd_count;
   int         fd_edge;
   bit         rand_ready;

   systolic_result_drain dut (
      .clk        (clk),
      .reset      (reset),
      .cap        (cap),
      .c_in       (c_in),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected frame: header, the 16 results C0..C15, XOR of the results.
   task automatic build_exp(input logic [127:0] c);
      logic [7:0] x;
      x = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back(c[k*8 +: 8]);
         x = x ^ c[k*8 +: 8];
      end
      exp_q.push_back(x);
   endtask

   function automatic logic [127:0] rand_vec();
      logic [127:0] v;
      for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'($urandom_range(0, 255));
      return v;
   endfunction

   // One clock: record a transfer seen before the edge, sample #1 after it.
   task automatic tick();
      logic       pre_v, pre_r;
      logic [7:0] pre_d;
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      pre_v = tx_valid;
      pre_r = tx_ready;
      pre_d = tx_data;
      @(posedge clk);
      #1;
      edge_n++;
      if (pre_v && pre_r && !reset) begin
         rx_q.push_back(pre_d);
         xfer_edges.push_back(edge_n);
      end
      if (pre_v && !pre_r && !reset) begin
         check("hold_valid", 32'(tx_valid), 32'd1);
         check("hold_data", 32'(tx_data), 32'(pre_d));
      end
      if (frame_done) begin
         fd_count++;
         fd_edge = edge_n;
      end
   endtask

   task automatic start_frame(input logic [127:0] c);
      rx_q.delete();
      xfer_edges.delete();
      edge_n = -1;
      c_in = c;
      cap = 1'b1;
      tick();
      cap = 1'b0;
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int start;
      start = fd_count;
      for (int i = 0; i < budget; i++) begin
         if (fd_count > start) break;
         tick();
      end
      check({tag, "_done_in_budget"}, 32'(fd_count > start), 32'd1);
   endtask

   task automatic compare_frame(input string tag);
      int n;
      check({tag, "_len"}, 32'(rx_q.size()), 32'd18);
      n = (rx_q.size() < 18) ? rx_q.size() : 18;
      for (int i = 0; i < n; i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      logic [127:0] c1, c2;
      int           fd0;

      reset = 1'b1; cap = 1'b0; c_in = '0; tx_ready = 1'b0;
      rand_ready = 1'b0; fd_count = 0; edge_n = 0; fd_edge = -1;

      // Reset values hold before any clock edge.
      #3;
      check("rst_tx_data", 32'(tx_data), 32'h00);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      tick();

      // Incrementing results, tx_ready held high: exact edge timing.
      for (int k = 0; k < 16; k++) c1[k*8 +: 8] = 8'(k + 1);
      build_exp(c1);
      tx_ready = 1'b1;
      fd_count = 0;
      start_frame(c1);
      check("a_hdr_valid", 32'(tx_valid), 32'd1);
      check("a_hdr_data", 32'(tx_data), 32'hA5);
      check("a_busy", 32'(busy), 32'd1);
      run_until_done("a", 40);
      compare_frame("a");
      if (rx_q.size() == 18) check("a_csum_10", 32'(rx_q[17]), 32'h10);
      if (xfer_edges.size() == 18) begin
         check("a_hdr_edge", 32'(xfer_edges[0]), 32'd1);
         check("a_csum_edge", 32'(xfer_edges[17]), 32'd18);
      end
      check("a_fd_edge", 32'(fd_edge), 32'd18);
      tick();
      check("a_fd_one_cycle", 32'(frame_done), 32'd0);
      check("a_idle_valid", 32'(tx_valid), 32'd0);
      check("a_idle_busy", 32'(busy), 32'd0);
      check("a_idle_data_held", 32'(tx_data), 32'h10);
      check("a_fd_count", 32'(fd_count), 32'd1);

      // Backpressure for 3 cycles while C4 (05) is offered.
      start_frame(c1);
      for (int i = 0; i < 10; i++) begin
         if (tx_valid && tx_data == 8'h05) break;
         tick();
      end
      check("b_c4_offered", 32'(tx_data), 32'h05);
      tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("b_stall_valid", 32'(tx_valid), 32'd1);
         check("b_stall_data", 32'(tx_data), 32'h05);
      end
      tx_ready = 1'b1;
      run_until_done("b", 40);
      compare_frame("b");

      // Ignored capture during DATA sets sticky overrun, frame unchanged.
      c1 = rand_vec();
      build_exp(c1);
      start_frame(c1);
      repeat (5) tick();
      c_in = {16{8'h33}};
      cap = 1'b1;
      tick();
      cap = 1'b0;
      check("c_overrun_set", 32'(overrun), 32'd1);
      run_until_done("c", 40);
      compare_frame("c");
      tick();
      check("c_overrun_sticky", 32'(overrun), 32'd1);
      c2 = rand_vec();
      build_exp(c2);
      start_frame(c2);
      check("c_overrun_clear", 32'(overrun), 32'd0);
      run_until_done("c2", 40);
      compare_frame("c2");
      tick();

      // Asynchronous reset mid-cycle while C6 is offered.
      c1 = rand_vec();
      build_exp(c1);
      start_frame(c1);
      repeat (3) tick();
      cap = 1'b1; c_in = ~c1;
      tick();
      cap = 1'b0;
      check("d_overrun_pre", 32'(overrun), 32'd1);
      repeat (3) tick();
      check("d_c6_offered", 32'(tx_data), 32'(exp_q[7]));
      fd0 = fd_count;
      #2 reset = 1'b1;
      #1;
      check("d_rst_valid", 32'(tx_valid), 32'd0);
      check("d_rst_busy", 32'(busy), 32'd0);
      check("d_rst_overrun", 32'(overrun), 32'd0);
      check("d_rst_data", 32'(tx_data), 32'h00);
      check("d_rst_fd", 32'(frame_done), 32'd0);
      repeat (2) tick();
      check("d_no_fd", 32'(fd_count), 32'(fd0));
      reset = 1'b0;
      tick();
      c2 = rand_vec();
      build_exp(c2);
      start_frame(c2);
      run_until_done("d", 40);
      compare_frame("d");
      check("d_fd_once", 32'(fd_count - fd0), 32'd1);

      // Capture on the checksum transfer edge: back-to-back frames.
      c1 = rand_vec();
      build_exp(c1);
      start_frame(c1);
      for (int i = 0; i < 40; i++) begin
         if (rx_q.size() == 17) break;
         tick();
      end
      c_in = {16{8'hFF}};
      cap = 1'b1;
      tick();
      cap = 1'b0;
      check("e_fd_pulse", 32'(frame_done), 32'd1);
      check("e_next_valid", 32'(tx_valid), 32'd1);
      check("e_next_hdr", 32'(tx_data), 32'hA5);
      check("e_busy", 32'(busy), 32'd1);
      check("e_overrun", 32'(overrun), 32'd0);
      compare_frame("e1");
      build_exp({16{8'hFF}});
      rx_q.delete();
      run_until_done("e2", 40);
      compare_frame("e2");
      if (rx_q.size() == 18) check("e2_csum_00", 32'(rx_q[17]), 32'h00);
      tick();

      // Random 50% backpressure for 10 frames.
      rand_ready = 1'b1;
      for (int f = 0; f < 10; f++) begin
         c1 = rand_vec();
         build_exp(c1);
         fd0 = fd_count;
         start_frame(c1);
         run_until_done($sformatf("f%0d", f), 400);
         repeat (2) tick();
         compare_frame($sformatf("f%0d", f));
         check($sformatf("f%0d_fd_once", f), 32'(fd_count - fd0), 32'd1);
      end
      rand_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001: Parameter HEADER, default 8'hA5, is the frame start byte sent before the result bytes.
REQ-002: Parameter N_RES, default 16, is the number of 8-bit results per frame; the 4x4 array fixes it at 16.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: reset  input  1  reset, asynchronous and active-high.
REQ-005: cap  input  1  capture request: sample the c_in results and start a frame.
REQ-006: c_in  input  8*N_RES  packed array results; C0 in [7:0], C1 in [15:8], ..., C15 in [127:120].
REQ-007: tx_data  output  8  byte offered to the UART transmitter.
REQ-008: tx_valid  output  1  tx_data is valid.
REQ-009: tx_ready  input  1  UART transmitter accepts the byte.
REQ-010: busy  output  1  a frame is in progress (state other than IDLE).
REQ-011: frame_done  output  1  one-cycle pulse after the checksum byte transfers.
REQ-012: overrun  output  1  sticky flag: a cap was ignored while busy.

Function
REQ-013: The state machine SHALL have the states IDLE, HDR, DATA and CSUM, with the transitions IDLE->HDR on cap, HDR->DATA on transfer, DATA->CSUM after the transfer of byte N_RES-1, and CSUM->IDLE on transfer.
REQ-014: A transfer SHALL occur exactly on a rising edge where tx_valid=1 and tx_ready=1.
REQ-015: While tx_valid=1 and no transfer occurs, tx_data and tx_valid SHALL hold stable; tx_valid SHALL NOT drop before its transfer.
REQ-016: On an edge where cap=1 in IDLE, all N_RES results SHALL be registered into an internal buffer; tx_valid=1 and tx_data=HEADER SHALL appear in the following cycle.
REQ-017: DATA SHALL send the buffer bytes in order C0 through C15, using a 4-bit index from 0 to N_RES-1 that advances only on a transfer.
REQ-018: CSUM SHALL send the XOR of the N_RES buffered bytes; the header is excluded from the XOR.
REQ-019: The checksum SHALL be accumulated from the buffer as bytes are sent, or computed at capture; either way it SHALL equal the XOR of the captured values.
REQ-020: With tx_ready held at 1 and cap sampled at edge 0, the header SHALL transfer at edge 1, data at edges 2 to 17, the checksum at edge 18, and frame_done SHALL be high for the cycle following edge 18.
REQ-021: A cap=1 at the same edge as the checksum transfer SHALL be accepted, giving a new capture and HDR next cycle with no idle gap; frame_done SHALL still pulse.
REQ-022: A cap=1 at any other edge while busy SHALL be ignored, the buffer SHALL be unchanged, and overrun SHALL be set.
REQ-023: overrun SHALL clear on the next accepted cap, unless that same edge also sets it.
REQ-024: Changes on c_in outside an accepted capture edge SHALL NOT affect an in-progress frame.
REQ-025: In IDLE, tx_valid SHALL be 0 and tx_data SHALL hold its last value.

Reset
REQ-026: Asserting reset SHALL immediately force state=IDLE, tx_data=8'h00, tx_valid=0, busy=0, frame_done=0, overrun=0, index=0, checksum=0 and buffer=0, independent of clk.
REQ-027: Reset in the middle of a frame SHALL abandon the frame without a frame_done pulse; the first cap after reset is released SHALL start a complete new frame.

Structure
REQ-028: The state encoding and the constants N_RES=16, RES_W=8 and HEADER_DEF=8'hA5 SHALL reside in the shared package systolic_pkg.
REQ-029: The block SHALL be a single module with no sub-module; the 16-to-1 byte select SHALL be an indexed read of the buffer.

Verification
REQ-030: Set C_k=k+1 (k=0..15), pulse cap, hold tx_ready=1 -> byte stream A5,01,02,...,10,10 (checksum 8'h10), frame_done one cycle after the edge-18 transfer.
REQ-031: Hold tx_ready=0 for 3 cycles while byte C4=05 is offered -> tx_data stays 05 with tx_valid=1 throughout; stream otherwise unchanged.
REQ-032: Pulse cap during DATA with c_in all 8'h33 -> overrun=1, current frame bytes unchanged; the next accepted cap clears overrun.
REQ-033: Assert reset asynchronously mid-clock while C6 is offered -> tx_valid, busy and overrun are 0 before the next edge, with no frame_done.
REQ-034: Set cap=1 at the checksum transfer edge with new c_in all 8'hFF -> A5 is offered in the next cycle, and that frame's checksum is 00.
REQ-035: Toggle tx_ready randomly at 50% for 10 frames -> every frame is 18 bytes with the correct checksum, and exactly one frame_done per frame.
